// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done operand and result bundle for serial_adder (ovf present with OVERFLOW_FLAG_EN)
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;

  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder/subtractor on one full-adder cell; OVERFLOW_FLAG_EN adds signed overflow flag
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_r;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef OVERFLOW_FLAG_EN
  logic             r_ovf;
`endif

  logic             w_load;
  logic             w_last;
  logic             w_s;
  logic             w_carry;

  // The single full-adder cell working on the current LSBs
  assign w_s     = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_carry = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE accepts start just like IDLE for back-to-back operation
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand load, bit-serial shifting and result capture on the final bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_r    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_load) begin
      // Subtraction is a + ~b + 1, so invert b and force the carry-in
      r_sa  <= bus.a;
      r_sb  <= bus.sub ? ~bus.b : bus.b;
      r_c   <= bus.sub ? 1'b1 : bus.cin;
      r_r   <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_c   <= w_carry;
      r_r   <= {w_s, r_r[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= {w_s, r_r[WIDTH-1:1]};
        r_cout <= w_carry;
`ifdef OVERFLOW_FLAG_EN
        // r_c here is the carry into the MSB
        r_ovf  <= r_c ^ w_carry;
`endif
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef OVERFLOW_FLAG_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule
